// File: rtl/branch_sequencer.sv
// branch_sequencer: control-unit slice for the conditional-branch instruction.
// Latency: start accepted at end of T2 -> T3..T6 strobes -> done pulse 5 cycles after start (no hold).
// Backpressure: hold freezes the sequence, gates load strobes, and blocks start acceptance in IDLE.
//
// Ports:
//   clock, reset_n              : clock, asynchronous active-low reset
//   start, ir, con_in, hold     : fetch request, instruction, CON result, datapath stall
//   gra..pc_in                  : datapath strobes (Moore, decoded from state)
//   busy, done, taken           : sequence status and last branch outcome
//   taken_cnt, not_taken_cnt    : saturating outcome counters
module branch_sequencer #(
  parameter logic [4:0] OPC_BR = 5'b10010,
  parameter int         CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [31:0]      ir,
  input  logic             con_in,
  input  logic             hold,
  output logic             gra,
  output logic             r_out,
  output logic             con_en,
  output logic             pc_out,
  output logic             y_in,
  output logic             c_out,
  output logic             alu_add,
  output logic             z_in,
  output logic             zlow_out,
  output logic             pc_in,
  output logic             busy,
  output logic             done,
  output logic             taken,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] not_taken_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T3   = 3'd1,
    S_T4   = 3'd2,
    S_T5   = 3'd3,
    S_T6   = 3'd4,
    S_FIN  = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic             taken_r_q, taken_r_d;
  logic             taken_q, taken_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] not_taken_cnt_q, not_taken_cnt_d;

  // Only the opcode field matters; the remaining IR bits belong to the datapath.
  logic unused_ir;
  assign unused_ir = ^ir[26:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      taken_r_q       <= 1'b0;
      taken_q         <= 1'b0;
      taken_cnt_q     <= '0;
      not_taken_cnt_q <= '0;
    end else begin
      state_q         <= state_d;
      taken_r_q       <= taken_r_d;
      taken_q         <= taken_d;
      taken_cnt_q     <= taken_cnt_d;
      not_taken_cnt_q <= not_taken_cnt_d;
    end
  end

  // Next-state: every transition out of a non-IDLE state waits for an un-held cycle.
  always_comb begin
    state_d         = state_q;
    taken_r_d       = taken_r_q;
    taken_d         = taken_q;
    taken_cnt_d     = taken_cnt_q;
    not_taken_cnt_d = not_taken_cnt_q;
    case (state_q)
      S_IDLE: if (start && !hold && ir[31:27] == OPC_BR) state_d = S_T3;
      S_T3:   if (!hold) state_d = S_T4;
      S_T4: begin
        if (!hold) begin
          state_d   = S_T5;
          // CON settled after CONin in T3; this edge is the only capture point.
          taken_r_d = con_in;
        end
      end
      S_T5:   if (!hold) state_d = S_T6;
      S_T6: begin
        if (!hold) begin
          state_d = S_FIN;
          taken_d = taken_r_q;
          if (taken_r_q) begin
            if (taken_cnt_q != CNT_MAX) taken_cnt_d = taken_cnt_q + CNT_ONE;
          end else begin
            if (not_taken_cnt_q != CNT_MAX) not_taken_cnt_d = not_taken_cnt_q + CNT_ONE;
          end
        end
      end
      // FIN never chains into T3, which enforces the 6-cycle branch spacing.
      S_FIN:   if (!hold) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobe decode: bus drivers follow the state; load enables are suppressed under hold.
  always_comb begin
    gra      = 1'b0;
    r_out    = 1'b0;
    con_en   = 1'b0;
    pc_out   = 1'b0;
    y_in     = 1'b0;
    c_out    = 1'b0;
    alu_add  = 1'b0;
    z_in     = 1'b0;
    zlow_out = 1'b0;
    pc_in    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_T3: begin
        gra    = 1'b1;
        r_out  = 1'b1;
        con_en = !hold;
        busy   = 1'b1;
      end
      S_T4: begin
        pc_out = 1'b1;
        y_in   = !hold;
        busy   = 1'b1;
      end
      S_T5: begin
        c_out   = 1'b1;
        alu_add = 1'b1;
        z_in    = !hold;
        busy    = 1'b1;
      end
      S_T6: begin
        zlow_out = 1'b1;
        pc_in    = taken_r_q && !hold;
        busy     = 1'b1;
      end
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

  assign taken         = taken_q;
  assign taken_cnt     = taken_cnt_q;
  assign not_taken_cnt = not_taken_cnt_q;

endmodule
